// File: rtl/counter_mod_updown_if.sv
// counter_mod_updown_if
//   Groups the control and status signals of counter_mod_updown.
//   Parameter WIDTH must match the counter it is attached to.
//   Signals:
//     Enable, Up, Load, LoadValue[WIDTH-1:0]   driven by the master (user logic)
//     Count[WIDTH-1:0], TerminalCount, Wrap,
//     LoadError                                driven by the slave (counter)
//   Modports: master (user side), slave (counter side).
interface counter_mod_updown_if #(
  parameter int WIDTH = 4
);
  logic             Enable;
  logic             Up;
  logic             Load;
  logic [WIDTH-1:0] LoadValue;
  logic [WIDTH-1:0] Count;
  logic             TerminalCount;
  logic             Wrap;
  logic             LoadError;

  modport master (
    output Enable, Up, Load, LoadValue,
    input  Count, TerminalCount, Wrap, LoadError
  );

  modport slave (
    input  Enable, Up, Load, LoadValue,
    output Count, TerminalCount, Wrap, LoadError
  );
endinterface

// File: rtl/counter_mod_updown.sv
// counter_mod_updown
//   Synchronous up/down counter over the range 0..MODULUS-1 with parallel
//   load (out-of-range loads clamp to MODULUS-1), count enable, and
//   wrap / terminal-count / load-error flags.
//   Parameters:
//     WIDTH        counter width, 1..32
//     MODULUS      count range 0..MODULUS-1, 2..2**WIDTH
//     RESET_VALUE  value taken on reset, below MODULUS
//   Ports:
//     Clock        rising-edge clock
//     Reset        synchronous active-high reset
//     bus          counter_mod_updown_if slave modport:
//                    Enable, Up, Load, LoadValue in;
//                    Count, TerminalCount (combinational), Wrap, LoadError out
//   Build option:
//     COUNTER_MOD_SATURATE_EN  when defined, an enabled step at a range limit
//                              holds the count and Wrap is tied to 0.
module counter_mod_updown #(
  parameter int              WIDTH       = 4,
  parameter longint unsigned MODULUS     = 16,
  parameter longint unsigned RESET_VALUE = 0
) (
  input logic                 Clock,
  input logic                 Reset,
  counter_mod_updown_if.slave bus
);

  // Comparisons run one bit wider than the counter so that MODULUS = 2**WIDTH
  // is representable and a LoadValue check against it does not truncate.
  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0] count;
  logic             load_error;
  logic             at_max;
  logic             at_zero;
  logic             load_too_big;

  assign at_max       = (count == MAX_COUNT);
  assign at_zero      = (count == '0);
  assign load_too_big = ({1'b0, bus.LoadValue} >= MOD_EXT);

  assign bus.Count         = count;
  assign bus.LoadError     = load_error;
  assign bus.TerminalCount = bus.Up ? at_max : at_zero;

`ifdef COUNTER_MOD_SATURATE_EN

  // Saturating variant: limits hold, so there is never a rollover to flag.
  assign bus.Wrap = 1'b0;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count      <= RST_COUNT;
      load_error <= 1'b0;
    end else if (bus.Load) begin
      count      <= load_too_big ? MAX_COUNT : bus.LoadValue;
      load_error <= load_too_big;
    end else begin
      load_error <= 1'b0;
      if (bus.Enable) begin
        if (bus.Up) begin
          if (!at_max) begin
            count <= count + 1'b1;
          end
        end else begin
          if (!at_zero) begin
            count <= count - 1'b1;
          end
        end
      end
    end
  end

`else

  logic wrap;

  assign bus.Wrap = wrap;

  // Wrap-around variant: stepping past either limit lands on the opposite
  // limit and raises Wrap for exactly that cycle.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count      <= RST_COUNT;
      wrap       <= 1'b0;
      load_error <= 1'b0;
    end else if (bus.Load) begin
      count      <= load_too_big ? MAX_COUNT : bus.LoadValue;
      load_error <= load_too_big;
      wrap       <= 1'b0;
    end else begin
      load_error <= 1'b0;
      wrap       <= 1'b0;
      if (bus.Enable) begin
        if (bus.Up) begin
          if (at_max) begin
            count <= '0;
            wrap  <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end else begin
          if (at_zero) begin
            count <= MAX_COUNT;
            wrap  <= 1'b1;
          end else begin
            count <= count - 1'b1;
          end
        end
      end
    end
  end

`endif

endmodule

// File: tb/tb_counter_mod_updown.sv
// tb_counter_mod_updown
//   Directed bench for counter_mod_updown. Two instances share clock and
//   reset: a decade counter (WIDTH=4, MODULUS=10) and a full-range counter
//   (WIDTH=4, MODULUS=16). Expectations follow COUNTER_MOD_SATURATE_EN when
//   it is defined for the build.
module tb_counter_mod_updown;

  logic Clock;
  logic Reset;

  counter_mod_updown_if #(.WIDTH(4)) dec_bus ();
  counter_mod_updown_if #(.WIDTH(4)) full_bus ();

  counter_mod_updown #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dut_dec (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (dec_bus.slave)
  );

  counter_mod_updown #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(0)) dut_full (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (full_bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       reset;
    logic       load;
    logic       enable;
    logic       up;
    logic [3:0] load_value;
    logic [3:0] count;
    logic       wrap;
    logic       load_error;
    logic       tc;
  } vec_t;

  vec_t vecs[13];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    Reset             = v.reset;
    dec_bus.Load      = v.load;
    dec_bus.Enable    = v.enable;
    dec_bus.Up        = v.up;
    dec_bus.LoadValue = v.load_value;
    tick();
  endtask

  int exp_up[12];
  int exp_down[4];
  int exp_full[17];
  int wrap_up_idx;
  int wrap_down_idx;
  int wrap_full_idx;
  int prev;

  initial begin
    Reset              = 1'b1;
    dec_bus.Enable     = 1'b0;
    dec_bus.Up         = 1'b1;
    dec_bus.Load       = 1'b0;
    dec_bus.LoadValue  = '0;
    full_bus.Enable    = 1'b0;
    full_bus.Up        = 1'b1;
    full_bus.Load      = 1'b0;
    full_bus.LoadValue = '0;

    // Fields: reset load enable up load_value | count wrap load_error tc
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd5,  4'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd12, 4'd9, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd5,  4'd5, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd3,  4'd3, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  4'd4, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  4'd4, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  4'd3, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 4'd9, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  4'd9, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  4'd0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd10, 4'd9, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd9,  4'd9, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0,  4'd0, 1'b0, 1'b0, 1'b0};

`ifdef COUNTER_MOD_SATURATE_EN
    exp_up        = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
    exp_down      = '{1, 0, 0, 0};
    exp_full      = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 15, 15};
    wrap_up_idx   = -1;
    wrap_down_idx = -1;
    wrap_full_idx = -1;
`else
    exp_up        = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    exp_down      = '{1, 0, 9, 8};
    exp_full      = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1};
    wrap_up_idx   = 9;
    wrap_down_idx = 2;
    wrap_full_idx = 15;
`endif

    // Table: reset state, loads, clamps, priority, hold, in-range steps.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d count", i), int'(dec_bus.Count), int'(vecs[i].count));
      checkOutput($sformatf("vec%0d wrap", i), int'(dec_bus.Wrap), int'(vecs[i].wrap));
      checkOutput($sformatf("vec%0d load_error", i), int'(dec_bus.LoadError), int'(vecs[i].load_error));
      checkOutput($sformatf("vec%0d terminal_count", i), int'(dec_bus.TerminalCount), int'(vecs[i].tc));
    end
    checkOutput("full reset count", int'(full_bus.Count), 0);

    // Decade counting up from 0 for 12 clocks.
    Reset = 1'b0;
    dec_bus.Load = 1'b0;
    dec_bus.Enable = 1'b1;
    dec_bus.Up = 1'b1;
    prev = 0;
    for (int i = 0; i < 12; i++) begin
      checkOutput($sformatf("up%0d tc_before", i), int'(dec_bus.TerminalCount), (prev == 9) ? 1 : 0);
      tick();
      checkOutput($sformatf("up%0d count", i), int'(dec_bus.Count), exp_up[i]);
      checkOutput($sformatf("up%0d wrap", i), int'(dec_bus.Wrap), (i == wrap_up_idx) ? 1 : 0);
      prev = exp_up[i];
    end

    // Load 2 then count down 4 clocks through zero.
    dec_bus.Load = 1'b1;
    dec_bus.LoadValue = 4'd2;
    dec_bus.Up = 1'b0;
    tick();
    checkOutput("down load count", int'(dec_bus.Count), 2);
    dec_bus.Load = 1'b0;
    prev = 2;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("down%0d tc_before", i), int'(dec_bus.TerminalCount), (prev == 0) ? 1 : 0);
      tick();
      checkOutput($sformatf("down%0d count", i), int'(dec_bus.Count), exp_down[i]);
      checkOutput($sformatf("down%0d wrap", i), int'(dec_bus.Wrap), (i == wrap_down_idx) ? 1 : 0);
      prev = exp_down[i];
    end

    // Direction flip at 9/0: TerminalCount follows Up without a clock.
    dec_bus.Enable = 1'b0;
    dec_bus.Load = 1'b1;
    dec_bus.LoadValue = 4'd9;
    tick();
    dec_bus.Load = 1'b0;
    dec_bus.Up = 1'b1;
    #1;
    checkOutput("flip up tc", int'(dec_bus.TerminalCount), 1);
    dec_bus.Up = 1'b0;
    #1;
    checkOutput("flip down tc", int'(dec_bus.TerminalCount), 0);

    // Full-range counter: 17 clocks up from 0.
    dec_bus.Enable = 1'b0;
    full_bus.Enable = 1'b1;
    full_bus.Up = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      checkOutput($sformatf("full%0d count", i), int'(full_bus.Count), exp_full[i]);
      checkOutput($sformatf("full%0d wrap", i), int'(full_bus.Wrap), (i == wrap_full_idx) ? 1 : 0);
    end
    full_bus.Enable = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/counter_mod_updown.md
# counter_mod_updown

Parametrised synchronous up/down counter with programmable modulus, parallel load, count enable and wrap/terminal-count flags. It is the general-purpose successor to the fixed 4-bit counter and is intended for decade counters, timers and clock-enable dividers elsewhere in the design. All state changes happen on the rising edge of `Clock`. An optional compile-time mode replaces wrap-around with saturation at the range limits.

## Interface
- `WIDTH`, default 4: counter width in bits; legal range 1 to 32.
- `MODULUS`, default 16: count range is 0 to MODULUS-1; legal range 2 to 2**WIDTH.
- `RESET_VALUE`, default 0: value loaded by reset; must be less than MODULUS.
- `Clock` input, 1 bit: the single clock; rising-edge active.
- `Reset` input, 1 bit: synchronous, active-high reset.
- `Enable` input, 1 bit: count enable; when 1, the counter advances one step per clock.
- `Up` input, 1 bit: direction; 1 counts up, 0 counts down.
- `Load` input, 1 bit: parallel-load strobe.
- `LoadValue` input, WIDTH bits: value taken when `Load` is 1.
- `Count` output, WIDTH bits: registered counter value.
- `TerminalCount` output, 1 bit: combinational; 1 when `Up`=1 and `Count`=MODULUS-1, or when `Up`=0 and `Count`=0.
- `Wrap` output, 1 bit: registered one-cycle pulse, set on the edge where the counter rolls over.
- `LoadError` output, 1 bit: registered one-cycle pulse, set on the edge where an out-of-range load is clamped.

## Operation
- Priority per edge: Reset, then Load, then Enable, then hold.
- **Reset = 1:**
  - `Count` becomes RESET_VALUE.
  - `Wrap` and `LoadError` become 0.
  - Load and Enable are ignored.
- **Load = 1, LoadValue < MODULUS:** `Count` becomes LoadValue and `LoadError` becomes 0.
- **Load = 1, LoadValue >= MODULUS:** `Count` becomes MODULUS-1 and `LoadError` becomes 1.
- **Load = 1, any LoadValue:** Enable is ignored and `Wrap` becomes 0.
- **Enable = 1, Up = 1:**
  - If `Count` < MODULUS-1: `Count` increments by 1.
  - If `Count` = MODULUS-1: `Count` becomes 0 and `Wrap` becomes 1.
- **Enable = 1, Up = 0:**
  - If `Count` > 0: `Count` decrements by 1.
  - If `Count` = 0: `Count` becomes MODULUS-1 and `Wrap` becomes 1.
- **Enable = 0 (and no Load):** `Count` holds.
- **Pulse flags:** `Wrap` and `LoadError` return to 0 on every edge where their set condition does not occur. They never stay high for two consecutive cycles unless the set condition repeats.
- **Width rule:** internal compare and arithmetic is WIDTH+1 bits wide, so MODULUS = 2**WIDTH is exact and does not truncate. `Count` never holds a value of MODULUS or above.
- **Direction change:** `Up` may change on any cycle and takes effect on the next enabled edge. `TerminalCount` follows `Up` combinationally, with no latency.

## Timing
- Latency from sampled `Enable`, `Load` or `Reset` to `Count` is 1 clock.
- `Wrap` and `LoadError` assert in the same cycle that `Count` shows the rolled-over or clamped value.
- `TerminalCount` is high in the cycle before an enabled edge produces `Wrap`.
- Output values before the first reset edge are unspecified. The bench must reset before checking.
- Reset mid-count: the next edge gives `Count` = RESET_VALUE with no `Wrap`, even if `Count` was at a terminal value with `Enable` = 1.

## Configuration
- Macro: `COUNTER_MOD_SATURATE_EN`.
- **Macro undefined (default):** wrap-around behaviour exactly as described in Operation.
- **Macro defined:** at the range limits, an enabled step holds the count instead of wrapping.
  - Counting up at MODULUS-1, `Count` stays at MODULUS-1.
  - Counting down at 0, `Count` stays at 0.
  - `Wrap` is never asserted and is driven constant 0.
- **Unaffected by the macro:** load, clamp, reset and `TerminalCount` behaviour.

## Test plan
- **Decade wrap:** WIDTH=4, MODULUS=10, reset, then `Enable`=1, `Up`=1 for 12 clocks.
  - `Count` goes 0,1,…,9,0,1,2.
  - `Wrap` is high only in the cycle `Count` returns to 0.
  - `TerminalCount` is high only while `Count`=9.
- **Down wrap:** load 2, then `Enable`=1, `Up`=0 for 4 clocks.
  - `Count` goes 2,1,0,9,8.
  - `Wrap` pulses with the value 9.
- **Load clamp:** `Load`=1 with `LoadValue`=12 and MODULUS=10 gives `Count`=9 and a one-cycle `LoadError` pulse. A following `LoadValue`=5 gives `Count`=5 with `LoadError`=0.
- **Priority:** apply `Reset`=1, `Load`=1 and `Enable`=1 together, then `Load`=1 with `Enable`=1.
  - All three together give `Count`=RESET_VALUE.
  - Load with Enable gives `Count`=LoadValue, not LoadValue+1.
- **Full range:** WIDTH=4, MODULUS=16, count up 17 clocks from 0.
  - `Count` reaches 15 and then 0 with a `Wrap` pulse.
  - No value of 16 or above appears.
- **Saturate:** MODULUS=10 with `COUNTER_MOD_SATURATE_EN` defined, counting up 12 clocks from 0.
  - `Count` stops at 9 and holds.
  - `Wrap` stays 0 throughout.
  - Counting down from 1 for 3 clocks holds at 0.
